// File: rtl/count_pkg.sv
// count_pkg: shared FSM encoding and default parameters for the count step decoder
package count_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_LOCK_CNT = 3;
  localparam int DEF_ERR_CNT_W = 8;
  localparam int MATCH_W = 4;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} step_state_t;
endpackage

// File: rtl/count_delta_calc.sv
// count_delta_calc: modular delta of count_in against prev, compared with cand and step
module count_delta_calc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] delta,
  output logic             eq_cand,
  output logic             eq_step
);
  assign delta   = count_in - prev;
  assign eq_cand = delta == cand;
  assign eq_step = delta == step;
endmodule

// File: rtl/count_step_decoder.sv
// count_step_decoder: recovers and checks the step of an accumulating counter; COUNT_STEP_ERRCNT_EN adds err_count
module count_step_decoder
  import count_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 resync,
  output logic [WIDTH-1:0]     step_out,
  output logic                 step_valid,
  output logic                 locked,
  output logic                 mismatch
`ifdef COUNT_STEP_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);
  step_state_t state, state_nxt;
  logic [WIDTH-1:0] prev, prev_nxt, cand, cand_nxt, step_nxt, delta;
  logic [MATCH_W-1:0] match_cnt, match_nxt, acq_cnt;
  logic eq_cand, eq_step, valid_nxt, mis_nxt;
  if (LOCK_CNT < 1 || LOCK_CNT > 15 || ERR_CNT_W < 1) begin : g_bad_param
    $error("count_step_decoder: illegal LOCK_CNT or ERR_CNT_W");
  end
  count_delta_calc #(.WIDTH(WIDTH)) u_delta (
    .count_in(count_in),
    .prev(prev),
    .cand(cand),
    .step(step_out),
    .delta(delta),
    .eq_cand(eq_cand),
    .eq_step(eq_step)
  );
  assign locked  = state == LOCKED;
  assign acq_cnt = (match_cnt == '0 || eq_cand) ? match_cnt + 1'b1 : MATCH_W'(1);
  // next-state and next-register values; resync overrides any coincident sample
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    cand_nxt  = cand;
    match_nxt = match_cnt;
    step_nxt  = step_out;
    valid_nxt = 1'b0;
    mis_nxt   = 1'b0;
    if (resync) begin
      state_nxt = IDLE;
      prev_nxt  = '0;
      cand_nxt  = '0;
      match_nxt = '0;
      step_nxt  = '0;
    end else if (sample_valid) begin
      prev_nxt = count_in;
      case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          match_nxt = '0;
        end
        ACQUIRE: begin
          cand_nxt  = delta;
          match_nxt = acq_cnt;
          if (acq_cnt >= MATCH_W'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            step_nxt  = delta;
          end
        end
        LOCKED: begin
          valid_nxt = eq_step;
          mis_nxt   = !eq_step;
          if (!eq_step) begin
            cand_nxt  = delta;
            match_nxt = MATCH_W'(1);
            state_nxt = ACQUIRE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      cand       <= '0;
      match_cnt  <= '0;
      step_out   <= '0;
      step_valid <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      cand       <= cand_nxt;
      match_cnt  <= match_nxt;
      step_out   <= step_nxt;
      step_valid <= valid_nxt;
      mismatch   <= mis_nxt;
    end
  end
`ifdef COUNT_STEP_ERRCNT_EN
  // saturating count of mismatch pulses, cleared by resync
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_count <= '0;
    else if (resync) err_count <= '0;
    else if (mis_nxt && err_count != '1) err_count <= err_count + 1'b1;
  end
`endif
endmodule

// File: tb/tb_count_step_decoder.sv
// tb_count_step_decoder: directed scoreboard bench for count_step_decoder
module tb_count_step_decoder;
  typedef struct packed {
    logic       l;
    logic [3:0] s;
    logic       sv;
    logic       mm;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_valid = 1'b0;
  logic [3:0] count_in = '0;
  logic resync = 1'b0;
  logic [3:0] step_out, step_out1;
  logic step_valid, locked, mismatch, step_valid1, locked1, mismatch1;
`ifdef COUNT_STEP_ERRCNT_EN
  logic [7:0] err_count, err_count1;
`endif
  exp_t q[$];
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  count_step_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .count_in(count_in), .resync(resync),
    .step_out(step_out), .step_valid(step_valid), .locked(locked), .mismatch(mismatch)
`ifdef COUNT_STEP_ERRCNT_EN
    , .err_count(err_count)
`endif
  );
  count_step_decoder #(.WIDTH(4), .LOCK_CNT(1), .ERR_CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .count_in(count_in), .resync(resync),
    .step_out(step_out1), .step_valid(step_valid1), .locked(locked1), .mismatch(mismatch1)
`ifdef COUNT_STEP_ERRCNT_EN
    , .err_count(err_count1)
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [3:0] c, input logic rs);
    @(negedge clk);
    sample_valid = v;
    count_in = c;
    resync = rs;
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string tag, input logic v, input logic [3:0] c, input logic rs,
                      input logic l, input logic [3:0] s, input logic sv, input logic mm);
    exp_t e;
    q.push_back(exp_t'{l, s, sv, mm});
    drive(v, c, rs);
    e = q.pop_front();
    check(tag, {25'd0, locked, step_out, step_valid, mismatch}, {25'd0, e});
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {locked, step_out, step_valid, mismatch}, 7'd0);
    @(negedge clk);
    reset = 1'b0;
    step("t1_s0", 1, 4'd0, 0, 0, 4'd0, 0, 0);
    step("t1_s2", 1, 4'd2, 0, 0, 4'd0, 0, 0);
    check("lock1_immediate", {locked1, step_out1}, {1'b1, 4'd2});
    step("t1_s4", 1, 4'd4, 0, 0, 4'd0, 0, 0);
    step("t1_s6", 1, 4'd6, 0, 1, 4'd2, 0, 0);
    step("t3_mis", 1, 4'd9, 0, 0, 4'd2, 0, 1);
    step("t3_s12", 1, 4'd12, 0, 0, 4'd2, 0, 0);
    step("t3_s15", 1, 4'd15, 0, 1, 4'd3, 0, 0);
    step("t2_resync", 0, 4'd0, 1, 0, 4'd0, 0, 0);
    step("t2_a12", 1, 4'd12, 0, 0, 4'd0, 0, 0);
    step("t2_a0", 1, 4'd0, 0, 0, 4'd0, 0, 0);
    step("t2_a4", 1, 4'd4, 0, 0, 4'd0, 0, 0);
    step("t2_a8", 1, 4'd8, 0, 1, 4'd4, 0, 0);
    for (int i = 0; i < 4; i++) step("t2_wrap", 1, 4'(12 + 4 * i), 0, 1, 4'd4, 1, 0);
    step("t2_idle", 0, 4'd9, 0, 1, 4'd4, 0, 0);
    step("t4_resync", 0, 4'd0, 1, 0, 4'd0, 0, 0);
    for (int i = 1; i < 4; i++) step("t4_acq", 1, 4'(i), 0, 0, 4'd0, 0, 0);
    step("t4_lock", 1, 4'd4, 0, 1, 4'd1, 0, 0);
    step("t4_s5", 1, 4'd5, 0, 1, 4'd1, 1, 0);
    for (int i = 0; i < 7; i++) step("t4_gap", 0, 4'(3 * i + 8), 0, 1, 4'd1, 0, 0);
    step("t4_s6", 1, 4'd6, 0, 1, 4'd1, 1, 0);
    step("z_resync", 0, 4'd0, 1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step("z_acq", 1, 4'd7, 0, 0, 4'd0, 0, 0);
    step("z_lock", 1, 4'd7, 0, 1, 4'd0, 0, 0);
    step("z_hold", 1, 4'd7, 0, 1, 4'd0, 1, 0);
    step("z_mis", 1, 4'd8, 0, 0, 4'd0, 0, 1);
    step("t5_resync", 0, 4'd0, 1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) step("t5_acq", 1, 4'(2 * i), 0, 0, 4'd0, 0, 0);
    step("t5_lock", 1, 4'd6, 0, 1, 4'd2, 0, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("t5_async_reset", {locked, step_out, step_valid, mismatch}, 7'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("t5_reacq", 1, 4'(2 * i), 0, 0, 4'd0, 0, 0);
    step("t5_relock", 1, 4'd6, 0, 1, 4'd2, 0, 0);
    step("t5_resync_sample", 1, 4'd8, 1, 0, 4'd0, 0, 0);
    step("t5_cap10", 1, 4'd10, 0, 0, 4'd0, 0, 0);
    step("t5_s12", 1, 4'd12, 0, 0, 4'd0, 0, 0);
    step("t5_s14", 1, 4'd14, 0, 0, 4'd0, 0, 0);
    step("t5_s0", 1, 4'd0, 0, 1, 4'd2, 0, 0);
`ifdef COUNT_STEP_ERRCNT_EN
    begin
      logic [3:0] c;
      step("t6_resync", 0, 4'd0, 1, 0, 4'd0, 0, 0);
      check("t6_err_cleared", err_count, 8'd0);
      c = 4'd0;
      drive(1, c, 0);
      for (int i = 0; i < 3; i++) begin
        c = c + 4'd1;
        drive(1, c, 0);
        c = c + 4'd2;
        drive(1, c, 0);
      end
      check("t6_err3", err_count1, 8'd3);
      check("t6_err_main0", err_count, 8'd0);
      for (int i = 0; i < 297; i++) begin
        c = c + 4'd1;
        drive(1, c, 0);
        c = c + 4'd2;
        drive(1, c, 0);
      end
      check("t6_err_sat", err_count1, 8'd255);
      drive(0, 4'd0, 1);
      check("t6_err_resync", err_count1, 8'd0);
    end
`endif
    @(negedge clk);
    sample_valid = 1'b0;
    resync = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
